// File: rtl/mmio_io_responder_if.sv
// rtl/mmio_io_responder_if.sv - CPU-side memory-mapped IO bus between control unit/datapath and the responder
interface mmio_io_responder_if;
  logic        io_read;
  logic        io_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output io_read,
    output io_write,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  io_read,
    input  io_write,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/mmio_io_responder.sv
// rtl/mmio_io_responder.sv - IO-window responder: debounced switches, LEDs, sticky buttons, 8-digit 7-seg scan
module mmio_io_responder #(
  parameter logic [31:0] IO_BASE         = 32'hFFFF_FC00,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
  parameter logic [16:0] SCAN_DIV        = 17'd100_000
) (
  input  logic                    clk,
  input  logic                    rst,
  mmio_io_responder_if.slave      bus,
  input  logic [15:0]             switch_in,
  input  logic [4:0]              button_in,
  output logic [15:0]             led_out,
  output logic [7:0]              seg_an,
  output logic [7:0]              seg_data
);

  localparam int NIN = 21;

  localparam logic [7:0] OFF_SW     = 8'h00;
  localparam logic [7:0] OFF_LED    = 8'h04;
  localparam logic [7:0] OFF_BTN    = 8'h08;
  localparam logic [7:0] OFF_SEGVAL = 8'h0C;
  localparam logic [7:0] OFF_SEGEN  = 8'h10;

  logic [15:0]    led;
  logic [31:0]    segval;
  logic [7:0]     segen;
  logic [4:0]     btn_flags;

  logic [NIN-1:0] sync1;
  logic [NIN-1:0] sync2;
  logic [NIN-1:0] stable;
  logic [19:0]    deb_cnt [NIN];
  logic [NIN-1:0] differ;
  logic [NIN-1:0] commit;
  logic [4:0]     btn_rise;

  logic [16:0]    scan_cnt;
  logic [2:0]     idx;

  logic           hit;
  logic [7:0]     offset;
  logic           wr_en;
  logic           btn_clr;

  // Address decode: strobe, window match and word alignment all required.
  always_comb begin
    offset  = bus.addr[7:0];
    hit     = (bus.io_read | bus.io_write) &&
              (bus.addr[31:8] == IO_BASE[31:8]) &&
              (bus.addr[1:0] == 2'b00);
    wr_en   = bus.io_write && hit;
    btn_clr = bus.io_read && hit && (offset == OFF_BTN);
  end

  always_comb begin
    bus.rdata = 32'h0;
    if (bus.io_read && hit) begin
      case (offset)
        OFF_SW:     bus.rdata = {16'h0, stable[15:0]};
        OFF_LED:    bus.rdata = {16'h0, led};
        OFF_BTN:    bus.rdata = {27'h0, btn_flags};
        OFF_SEGVAL: bus.rdata = segval;
        OFF_SEGEN:  bus.rdata = {24'h0, segen};
        default:    bus.rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led    <= 16'h0;
      segval <= 32'h0;
      segen  <= 8'h00;
    end else if (wr_en) begin
      case (offset)
        OFF_LED:    led    <= bus.wdata[15:0];
        OFF_SEGVAL: segval <= bus.wdata;
        OFF_SEGEN:  segen  <= bus.wdata[7:0];
        default:    ;
      endcase
    end
  end

  assign led_out = led;

  // Buttons occupy bits [20:16] of the shared synchroniser/debounce chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {button_in, switch_in};
      sync2 <= sync1;
    end
  end

  always_comb begin
    for (int i = 0; i < NIN; i++) begin
      differ[i] = sync2[i] != stable[i];
      commit[i] = differ[i] && (deb_cnt[i] == DEBOUNCE_CYCLES - 20'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < NIN; i++) deb_cnt[i] <= 20'd0;
    end else begin
      // A commit only happens on a differing bit, so XOR adopts the synced level.
      stable <= stable ^ commit;
      for (int i = 0; i < NIN; i++) begin
        if (!differ[i] || commit[i]) deb_cnt[i] <= 20'd0;
        else                         deb_cnt[i] <= deb_cnt[i] + 20'd1;
      end
    end
  end

  assign btn_rise = commit[20:16] & sync2[20:16];

  // A press landing on the same edge as a read-clear survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_flags <= 5'h0;
    else     btn_flags <= (btn_flags & ~(btn_clr ? 5'h1F : 5'h00)) | btn_rise;
  end

  function automatic logic [7:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 8'hC0;
      4'h1: hex7 = 8'hF9;
      4'h2: hex7 = 8'hA4;
      4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;
      4'h5: hex7 = 8'h92;
      4'h6: hex7 = 8'h82;
      4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;
      4'h9: hex7 = 8'h90;
      4'hA: hex7 = 8'h88;
      4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;
      4'hD: hex7 = 8'hA1;
      4'hE: hex7 = 8'h86;
      default: hex7 = 8'h8E;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= 17'd0;
      idx      <= 3'd0;
      seg_an   <= 8'hFF;
      seg_data <= 8'hFF;
    end else begin
      if (scan_cnt == SCAN_DIV - 17'd1) begin
        scan_cnt <= 17'd0;
        idx      <= idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 17'd1;
      end
      seg_an   <= segen[idx] ? ~(8'd1 << idx) : 8'hFF;
      seg_data <= hex7(segval[{idx, 2'b00} +: 4]);
    end
  end

endmodule
